// File: rtl/adder_pkg.sv
// adder_pkg: width helpers shared by the adder library
package adder_pkg;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int max_w(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rcla_block.sv
// rcla_block: combinational BW-bit carry look-ahead block with group generate/propagate carry-out
module rcla_block #(
  parameter int BW = 4
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          ci,
  output logic [BW-1:0] s,
  output logic          co
);
  logic [BW-1:0] g, p, c;
  logic gg, t;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    c = '0;
    gg = 1'b0;
    t = 1'b0;
    for (int i = 0; i < BW; i++) begin
      t = ci;
      for (int k = 0; k < i; k++) t = t & p[k];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        c[i] = c[i] | t;
      end
    end
    for (int j = 0; j < BW; j++) begin
      t = g[j];
      for (int k = j + 1; k < BW; k++) t = t & p[k];
      gg = gg | t;
    end
  end
  assign s = p ^ c;
  assign co = gg | (&p & ci);
endmodule

// File: rtl/rcla_pipe_adder.sv
// rcla_pipe_adder: pipelined ripple-block carry look-ahead adder with stall-all flow control
module rcla_pipe_adder
  import adder_pkg::*;
#(
  parameter  int XW = 8,
  parameter  int YW = 12,
  parameter  int BW = 4,
  localparam int W  = max_w(XW, YW)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] X,
  input  logic [YW-1:0] Y,
  input  logic          Cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    S
);
  localparam int NB = ceil_div(W, BW);
  localparam int WP = NB * BW;
  logic en;
  logic [NB-1:0] v_q, c_q, v_in, c_in, blk_co;
  logic [WP-1:0] a_q [NB];
  logic [WP-1:0] b_q [NB];
  logic [WP-1:0] sum_q [NB];
  logic [WP-1:0] a_in [NB];
  logic [WP-1:0] b_in [NB];
  logic [WP-1:0] sum_in [NB];
  logic [WP-1:0] sum_nx [NB];
  logic [BW-1:0] blk_s [NB];
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign out_valid = v_q[NB-1];
  for (genvar k = 0; k < NB; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_in[k] = in_valid;
      assign a_in[k] = WP'(X);
      assign b_in[k] = WP'(Y);
      assign c_in[k] = Cin;
      assign sum_in[k] = '0;
    end else begin : g_tail
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign sum_in[k] = sum_q[k-1];
    end
    rcla_block #(.BW(BW)) u_block (
      .a  (a_in[k][k*BW +: BW]),
      .b  (b_in[k][k*BW +: BW]),
      .ci (c_in[k]),
      .s  (blk_s[k]),
      .co (blk_co[k])
    );
    assign sum_nx[k] = sum_in[k] | (WP'(blk_s[k]) << (k * BW));
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q <= '0;
      c_q <= '0;
      for (int i = 0; i < NB; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else if (en) begin
      v_q <= v_in;
      c_q <= blk_co;
      a_q <= a_in;
      b_q <= b_in;
      sum_q <= sum_nx;
    end
  end
  if (WP > W) begin : g_pad
    assign S = {sum_q[NB-1][W] | c_q[NB-1], sum_q[NB-1][W-1:0]};
  end else begin : g_exact
    assign S = {c_q[NB-1], sum_q[NB-1][W-1:0]};
  end
endmodule
